// File: rtl/dp_ram_burst_ctrl_if.sv
// dp_ram_burst_ctrl_if: bundle of the burst controller's command, stream and RAM signals.
//  master modport : the burst controller (drives cmd_ready, stream ready/valid, RAM strobes, done)
//  slave  modport : the environment (command source, stream clients, RAM instance)
//  Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len   burst command handshake
//   wr_s_valid/wr_s_ready/wr_s_data                  write stream into RAM
//   rd_m_valid/rd_m_ready/rd_m_data                  read stream out of RAM
//   ram_en/ram_wr_en/ram_rd_en/ram_wr_addr/ram_rd_addr/ram_wr_data/ram_rd_data   RAM port set
//   done                                             one-cycle burst completion pulse
//   cmd_err                                          one-cycle bad-address pulse (DPRC_ADDR_CHECK_EN)
interface dp_ram_burst_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned LEN_W = 4;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_s_valid;
  logic              wr_s_ready;
  logic [DATA_W-1:0] wr_s_data;

  logic              rd_m_valid;
  logic              rd_m_ready;
  logic [DATA_W-1:0] rd_m_data;

  logic              ram_en;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data;

  logic              done;
  logic              cmd_err;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_s_valid, wr_s_data,
    input  rd_m_ready,
    input  ram_rd_data,
    output cmd_ready, wr_s_ready, rd_m_valid, rd_m_data,
    output ram_en, ram_wr_en, ram_rd_en, ram_wr_addr, ram_rd_addr, ram_wr_data,
    output done, cmd_err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_s_valid, wr_s_data,
    output rd_m_ready,
    output ram_rd_data,
    input  cmd_ready, wr_s_ready, rd_m_valid, rd_m_data,
    input  ram_en, ram_wr_en, ram_rd_en, ram_wr_addr, ram_rd_addr, ram_wr_data,
    input  done, cmd_err
  );
endinterface

// File: rtl/dp_ram_burst_ctrl.sv
// dp_ram_burst_ctrl: burst initiator for an 8-bit dual-port RAM.
//  Takes one command at a time and runs it as 1..16 consecutive RAM accesses with
//  addresses wrapping modulo DEPTH. Write bursts drain the wr_s stream into RAM; read
//  bursts stream RAM words out on rd_m through a 2-entry buffer (one word per cycle
//  when rd_m_ready stays high).
// Ports:
//  clk  - clock, all logic on posedge
//  rst  - synchronous active-high reset; aborts any burst without a done pulse
//  bus  - dp_ram_burst_ctrl_if.master: command, write stream, read stream, RAM port, done, cmd_err
// Build option:
//  DPRC_ADDR_CHECK_EN - when defined, a command with cmd_addr >= DEPTH is consumed without any
//  RAM access and cmd_err pulses for one cycle instead of done. When undefined cmd_err is 0 and
//  cmd_addr is taken modulo DEPTH.
module dp_ram_burst_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  dp_ram_burst_ctrl_if.master bus
);

  localparam int unsigned LEN_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OCC_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef DPRC_ADDR_CHECK_EN
  localparam logic [2:0] S_ERR   = 3'd5;
`endif

  logic [2:0]        state;
  logic [2:0]        state_next;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  beats_left;

  // read return path: one-cycle in-flight flag plus a 2-entry circular buffer
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [DATA_W-1:0] buf_mem [2];
  logic [OCC_W-1:0]  occ;

  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_issue;
  logic              pop;
  logic              last_beat;

  assign cmd_fire  = (state == S_IDLE) && bus.cmd_valid;
  assign wr_fire   = (state == S_WRITE) && bus.wr_s_valid;
  assign pop       = (count != '0) && bus.rd_m_ready;
  assign last_beat = (beats_left == '0);

  // Occupancy after this cycle's pop; a new read may only be issued while it stays below 2,
  // so the word it returns next cycle always has a free buffer slot.
  assign occ      = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign rd_issue = (state == S_READ) && (occ < OCC_W'(2));

  assign addr_inc   = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
  assign start_addr = ADDR_W'(32'(bus.cmd_addr) % DEPTH);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_next = bus.cmd_write ? S_WRITE : S_READ;
`ifdef DPRC_ADDR_CHECK_EN
          if (32'(bus.cmd_addr) >= DEPTH) begin
            state_next = S_ERR;
          end
`endif
        end
      end
      S_WRITE: begin
        if (wr_fire && last_beat) begin
          state_next = S_DONE;
        end
      end
      S_READ: begin
        if (rd_issue && last_beat) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((count == '0) && !inflight) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
`ifdef DPRC_ADDR_CHECK_EN
      S_ERR: begin
        state_next = S_IDLE;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Burst address/length tracking and read return buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      beats_left <= '0;
      inflight   <= 1'b0;
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      if (cmd_fire) begin
        addr       <= start_addr;
        beats_left <= bus.cmd_len;
      end
      if (wr_fire || rd_issue) begin
        addr       <= addr_inc;
        beats_left <= beats_left - LEN_W'(1);
      end
      inflight <= rd_issue;
      if (inflight) begin
        buf_mem[wr_ptr] <= bus.ram_rd_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= CNT_W'(occ);
    end
  end

  // Handshake and status outputs are decoded from the state register
  assign bus.cmd_ready  = (state == S_IDLE);
  assign bus.wr_s_ready = (state == S_WRITE);
  assign bus.rd_m_valid = (count != '0);
  assign bus.rd_m_data  = buf_mem[rd_ptr];
  assign bus.done       = (state == S_DONE);
`ifdef DPRC_ADDR_CHECK_EN
  assign bus.cmd_err    = (state == S_ERR);
`else
  assign bus.cmd_err    = 1'b0;
`endif

  // RAM strobes follow the accepted beat in the same cycle; write and read are exclusive by state
  assign bus.ram_en      = wr_fire || rd_issue;
  assign bus.ram_wr_en   = wr_fire;
  assign bus.ram_rd_en   = rd_issue;
  assign bus.ram_wr_addr = addr;
  assign bus.ram_rd_addr = addr;
  assign bus.ram_wr_data = wr_fire ? bus.wr_s_data : '0;

endmodule

// File: tb/tb_dp_ram_burst_ctrl.sv
// tb_dp_ram_burst_ctrl: directed bench for dp_ram_burst_ctrl with a behavioural RAM.
module tb_dp_ram_burst_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  int both_cnt     = 0;
  int unstable_cnt = 0;
  int done_cnt     = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] exp_q [$];

  dp_ram_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  dp_ram_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // behavioural RAM: registered read, one cycle after ram_rd_en
  always @(posedge clk) begin
    if (bus_if.ram_en && bus_if.ram_wr_en) mem[bus_if.ram_wr_addr] <= bus_if.ram_wr_data;
    if (bus_if.ram_en && bus_if.ram_rd_en) bus_if.ram_rd_data <= mem[bus_if.ram_rd_addr];
  end

  // protocol watch: strobe exclusivity, stalled read beat stability, done pulses
  always @(posedge clk) begin
    if (bus_if.ram_wr_en && bus_if.ram_rd_en) both_cnt <= both_cnt + 1;
    if (prev_stall && !rst && (!bus_if.rd_m_valid || bus_if.rd_m_data != prev_data))
      unstable_cnt <= unstable_cnt + 1;
    prev_stall <= bus_if.rd_m_valid && !bus_if.rd_m_ready && !rst;
    prev_data  <= bus_if.rd_m_data;
    if (bus_if.done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [3:0] len);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = w;
    bus_if.cmd_addr  = a;
    bus_if.cmd_len   = len;
    #1;
    check_eq("cmd_ready_idle", 32'(bus_if.cmd_ready), 1);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                             input logic [DATA_W-1:0] base, input bit stall,
                             input int exp_start);
    send_cmd(1'b1, a, len);
    for (int i = 0; i <= int'(len); i++) begin
      if (stall && i == 1) begin
        bus_if.wr_s_valid = 1'b0;
        #1;
        check_eq("wr_stall_ram_en", 32'(bus_if.ram_en), 0);
        @(negedge clk);
      end
      bus_if.wr_s_valid = 1'b1;
      bus_if.wr_s_data  = 8'(int'(base) + i);
      #1;
      check_eq("wr_s_ready", 32'(bus_if.wr_s_ready), 1);
      check_eq("wr_ram_wr_en", 32'(bus_if.ram_wr_en), 1);
      check_eq("wr_ram_rd_en", 32'(bus_if.ram_rd_en), 0);
      check_eq("wr_ram_addr", 32'(bus_if.ram_wr_addr), 32'((exp_start + i) % 16));
      check_eq("wr_ram_data", 32'(bus_if.ram_wr_data), 32'((int'(base) + i) % 256));
      @(negedge clk);
    end
    bus_if.wr_s_valid = 1'b0;
    #1;
    check_eq("wr_done_pulse", 32'(bus_if.done), 1);
    check_eq("wr_done_ram_en", 32'(bus_if.ram_en), 0);
    @(negedge clk);
    #1;
    check_eq("wr_done_clear", 32'(bus_if.done), 0);
    check_eq("wr_back_idle", 32'(bus_if.cmd_ready), 1);
  endtask

  // expected read data is taken from exp_q; rdy_pat bit c%4 drives rd_m_ready in loop cycle c
  task automatic read_burst(input logic [ADDR_W-1:0] a, input logic [3:0] len,
                            input logic [3:0] rdy_pat, input bit hold, input int exp_start);
    int  k;
    int  iss;
    int  first;
    int  last;
    bit  seen_done;
    k = 0; iss = 0; first = -1; last = -1; seen_done = 1'b0;
    send_cmd(1'b0, a, len);
    if (hold) bus_if.cmd_valid = 1'b1;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      bus_if.rd_m_ready = rdy_pat[c % 4];
      #1;
      if (hold && c == 0) check_eq("busy_cmd_ready", 32'(bus_if.cmd_ready), 0);
      if (bus_if.ram_rd_en) begin
        check_eq("rd_ram_addr", 32'(bus_if.ram_rd_addr), 32'((exp_start + iss) % 16));
        iss++;
      end
      if (bus_if.rd_m_valid && bus_if.rd_m_ready) begin
        if (k < exp_q.size()) check_eq("rd_m_data", 32'(bus_if.rd_m_data), 32'(exp_q[k]));
        if (first < 0) first = c;
        last = c;
        k++;
      end
      if (bus_if.done) begin
        seen_done = 1'b1;
        bus_if.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.rd_m_ready = 1'b0;
    bus_if.cmd_valid  = 1'b0;
    check_eq("rd_done_seen", 32'(seen_done), 1);
    check_eq("rd_beats", 32'(k), 32'(int'(len) + 1));
    check_eq("rd_issues", 32'(iss), 32'(int'(len) + 1));
    if (rdy_pat == 4'hF) check_eq("rd_back_to_back", 32'(last - first), 32'(len));
    #1;
    check_eq("rd_done_clear", 32'(bus_if.done), 0);
    check_eq("rd_back_idle", 32'(bus_if.cmd_ready), 1);
  endtask

  task automatic check_reset_outputs(input string phase);
    check_eq({phase, "_cmd_ready"}, 32'(bus_if.cmd_ready), 1);
    check_eq({phase, "_wr_s_ready"}, 32'(bus_if.wr_s_ready), 0);
    check_eq({phase, "_rd_m_valid"}, 32'(bus_if.rd_m_valid), 0);
    check_eq({phase, "_rd_m_data"}, 32'(bus_if.rd_m_data), 0);
    check_eq({phase, "_ram_en"}, 32'(bus_if.ram_en), 0);
    check_eq({phase, "_ram_wr_en"}, 32'(bus_if.ram_wr_en), 0);
    check_eq({phase, "_ram_rd_en"}, 32'(bus_if.ram_rd_en), 0);
    check_eq({phase, "_ram_rd_addr"}, 32'(bus_if.ram_rd_addr), 0);
    check_eq({phase, "_done"}, 32'(bus_if.done), 0);
    check_eq({phase, "_cmd_err"}, 32'(bus_if.cmd_err), 0);
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    bus_if.ram_rd_data = '0;
    bus_if.cmd_valid   = 1'b0;
    bus_if.cmd_write   = 1'b0;
    bus_if.cmd_addr    = '0;
    bus_if.cmd_len     = '0;
    bus_if.wr_s_valid  = 1'b0;
    bus_if.wr_s_data   = '0;
    bus_if.rd_m_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clk);

    // write 2..5 with A0..A3, then 6..9 with B0..B3
    write_burst(5'd2, 4'd3, 8'hA0, 1'b0, 2);
    @(negedge clk);
    write_burst(5'd6, 4'd3, 8'hB0, 1'b0, 6);
    @(negedge clk);

    // full-rate read back
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    read_burst(5'd2, 4'd3, 4'hF, 1'b0, 2);
    @(negedge clk);

    // 8-beat read with ready pattern 1,0,0,1 and cmd_valid held during the burst
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    read_burst(5'd2, 4'd7, 4'b1001, 1'b1, 2);
    @(negedge clk);

    // wrapping write with a one-cycle stream stall, then wrapping read back
    write_burst(5'd14, 4'd3, 8'hC0, 1'b1, 14);
    @(negedge clk);
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    read_burst(5'd14, 4'd3, 4'hF, 1'b0, 14);
    @(negedge clk);
    check_eq("mem_wrap_0", 32'(mem[0]), 32'h00C2);
    check_eq("mem_wrap_15", 32'(mem[15]), 32'h00C1);

    // reset in the middle of a stalled read burst
    send_cmd(1'b0, 5'd2, 4'd7);
    bus_if.rd_m_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("mid_rd_valid", 32'(bus_if.rd_m_valid), 1);
    check_eq("mid_rd_data", 32'(bus_if.rd_m_data), 32'h00A0);
    dc = done_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("midrst_no_done", 32'(done_cnt - dc), 0);
    check_eq("midrst_idle", 32'(bus_if.cmd_ready), 1);
    @(negedge clk);

    // out-of-range start address
`ifdef DPRC_ADDR_CHECK_EN
    send_cmd(1'b1, 5'd20, 4'd0);
    bus_if.wr_s_valid = 1'b1;
    bus_if.wr_s_data  = 8'hD5;
    #1;
    check_eq("err_pulse", 32'(bus_if.cmd_err), 1);
    check_eq("err_ram_en", 32'(bus_if.ram_en), 0);
    check_eq("err_no_done", 32'(bus_if.done), 0);
    @(negedge clk);
    bus_if.wr_s_valid = 1'b0;
    #1;
    check_eq("err_clear", 32'(bus_if.cmd_err), 0);
    check_eq("err_idle", 32'(bus_if.cmd_ready), 1);
    check_eq("err_mem4", 32'(mem[4]), 32'h00A2);
    @(negedge clk);
`else
    write_burst(5'd20, 4'd0, 8'hD5, 1'b0, 4);
    @(negedge clk);
    check_eq("mod_mem4", 32'(mem[4]), 32'h00D5);
    check_eq("mod_cmd_err", 32'(bus_if.cmd_err), 0);
    exp_q = '{8'hD5};
    read_burst(5'd20, 4'd0, 4'hF, 1'b0, 4);
    @(negedge clk);
`endif

    check_eq("strobe_exclusive", 32'(both_cnt), 0);
    check_eq("rd_beat_stable", 32'(unstable_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
